// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM state
// enum and a helper that folds the reserved size code onto a word access.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_MERGE = 3'd2,
        ST_WR    = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    function automatic logic [1:0] norm_size(input logic [1:0] size);
        return (size == 2'b11) ? SZ_W : size;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane helper: merges store data into a read word and extracts/extends
// load data from a word. Half accesses always use off_i[1] (low bit ignored).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        merged_o = word_i;
        load_o   = word_i;
        byte_v   = word_i[{off_i, 3'b000} +: 8];
        half_v   = word_i[{off_i[1], 4'b0000} +: 16];
        case (size_i)
            SZ_B: begin
                merged_o[{off_i, 3'b000} +: 8] = wdata_i[7:0];
                load_o = unsigned_i ? {24'h0, byte_v} : {{24{byte_v[7]}}, byte_v};
            end
            SZ_H: begin
                merged_o[{off_i[1], 4'b0000} +: 16] = wdata_i[15:0];
                load_o = unsigned_i ? {16'h0, half_v} : {{16{half_v[15]}}, half_v};
            end
            default: begin
                merged_o = wdata_i;
                load_o   = word_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit to a word-wide memory: sub-word stores use read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned half/word accesses instead of truncating.
//
// state    | meaning
// IDLE     | ready for a request
// RD       | mem_read held until ack, read word captured
// MERGE    | store data merged into captured word
// WR       | mem_write held until ack
// RESP     | one-cycle load write-back
module mem_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic [TAG_W-1:0]  wb_tag,
    output logic              misalign
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              write_q, write_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [31:0]       word_q, word_d;
    logic              ready_q, ready_d;
    logic              misalign_q, misalign_d;

    logic        accept;
    logic [1:0]  nsize;
    logic        misal_req;
    logic [31:0] merged, load_data;

    assign accept = req_valid && req_ready;
    assign nsize  = norm_size(req_size);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misal_req = ((nsize == SZ_H) && req_addr[0]) ||
                       ((nsize == SZ_W) && (req_addr[1:0] != 2'b00));
`else
    assign misal_req = 1'b0;
`endif

    lsu_align u_align (
        .word_i     (word_q),
        .wdata_i    (wdata_q),
        .off_i      (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .merged_o   (merged),
        .load_o     (load_data)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        uns_d      = uns_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        tag_d      = tag_q;
        word_d     = word_q;
        misalign_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = req_addr;
                    size_d  = nsize;
                    uns_d   = req_unsigned;
                    write_d = req_write;
                    wdata_d = req_wdata;
                    tag_d   = req_tag;
                    if (misal_req) begin
                        misalign_d = 1'b1;
                    end else if (req_write && (nsize == SZ_W)) begin
                        word_d  = req_wdata;
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (mem_ack) begin
                    word_d  = mem_rdata;
                    state_d = write_q ? ST_MERGE : ST_RESP;
                end
            end
            ST_MERGE: begin
                word_d  = merged;
                state_d = ST_WR;
            end
            ST_WR: begin
                if (mem_ack) state_d = ST_IDLE;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        // ready is registered so it stays low while reset is held
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            size_q     <= SZ_B;
            uns_q      <= 1'b0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            tag_q      <= '0;
            word_q     <= '0;
            ready_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            tag_q      <= tag_d;
            word_q     <= word_d;
            ready_q    <= ready_d;
            misalign_q <= misalign_d;
        end
    end

    assign req_ready = ready_q;
    assign mem_read  = (state_q == ST_RD);
    assign mem_write = (state_q == ST_WR);
    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata = mem_write ? word_q : 32'h0;
    assign wb_valid  = (state_q == ST_RESP);
    assign wb_data   = wb_valid ? load_data : 32'h0;
    assign wb_tag    = wb_valid ? tag_q : '0;
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: directed loads/stores against a word memory model.
module tb_mem_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic [4:0]  req_tag;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, mem_ack;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_tag;
    logic        misalign;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ack_cyc  = 0;
    int wait_cyc = 0;
    int rd_cnt   = 0;
    int wr_cnt   = 0;

    logic [31:0] mem [0:63];
    logic [36:0] wb_q [$];
    logic [63:0] wr_q [$];

    mem_lsu #(.ADDR_W(32), .TAG_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .req_tag(req_tag),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_tag(wb_tag),
        .misalign(misalign)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // memory model: acks after wait_cyc cycles of a held strobe
    initial begin
        int cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n || mem_ack) begin
                mem_ack = 1'b0;
                cnt = 0;
            end else if (mem_read || mem_write) begin
                if (cnt >= wait_cyc) begin
                    mem_ack = 1'b1;
                    ack_cyc = cyc;
                    if (mem_read) begin
                        mem_rdata = mem[mem_addr[7:2]];
                        rd_cnt++;
                    end else begin
                        mem[mem_addr[7:2]] = mem_wdata;
                        wr_cnt++;
                        if (wr_q.size() == 0) chk("unexpected_write", {mem_addr, mem_wdata}, 64'h0);
                        else chk("mem_write", {mem_addr, mem_wdata}, wr_q.pop_front());
                    end
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // write-back monitor
    always @(negedge clk) begin
        if (rst_n) begin
            chk("strobe_excl", {63'h0, mem_read && mem_write}, 64'h0);
            if (wb_valid) begin
                if (wb_q.size() == 0) begin
                    chk("unexpected_wb", {27'h0, wb_tag, wb_data}, 64'h0);
                end else begin
                    logic [36:0] e;
                    e = wb_q.pop_front();
                    chk("wb_data", {32'h0, wb_data}, {32'h0, e[31:0]});
                    chk("wb_tag", {59'h0, wb_tag}, {59'h0, e[36:32]});
                    chk("wb_latency", 64'(cyc), 64'(ack_cyc + 1));
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", 64'h0, 64'h1);
    endtask

    task automatic issue(input logic [31:0] a, input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] wd, input logic [4:0] tg);
        wait_ready();
        req_addr = a; req_write = w; req_size = sz; req_unsigned = u;
        req_wdata = wd; req_tag = tg; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A; req_tag = 5'h1F;
        req_size = SZ_B; req_write = ~w; req_unsigned = ~u;
    endtask

    task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                        input logic [4:0] tg, input logic [31:0] exp);
        wb_q.push_back({tg, exp});
        issue(a, 1'b0, sz, u, 32'h0, tg);
    endtask

    task automatic store(input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] wd, input logic [63:0] exp);
        wr_q.push_back(exp);
        issue(a, 1'b1, sz, 1'b0, wd, 5'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0, wr0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'h8081_7F01;
        mem[5] = 32'h5566_7788;
        req_valid = 0; req_addr = 0; req_write = 0; req_size = 0;
        req_unsigned = 0; req_wdata = 0; req_tag = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {31'h0, req_ready, mem_read, mem_write, wb_valid, misalign, 28'h0},
            64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {63'h0, req_ready}, 64'h1);

        load(32'h13, SZ_B, 1'b0, 5'd1, 32'hFFFF_FF80);
        load(32'h13, SZ_B, 1'b1, 5'd2, 32'h0000_0080);
        load(32'h12, SZ_H, 1'b0, 5'd3, 32'hFFFF_8081);
        load(32'h10, SZ_H, 1'b1, 5'd4, 32'h0000_7F01);
        load(32'h11, SZ_B, 1'b0, 5'd5, 32'h0000_007F);
        load(32'h10, 2'b11, 1'b0, 5'd6, 32'h8081_7F01);
        wait_ready();
        wait_cyc = 3;
        load(32'h10, SZ_W, 1'b0, 5'd7, 32'h8081_7F01);
        wait_ready();
        wait_cyc = 0;

        mem[4] = 32'h1122_3344;
        store(32'h11, SZ_B, 32'hFFFF_FFAB, {32'h10, 32'h1122_AB44});
        store(32'h16, SZ_H, 32'h1234_CAFE, {32'h14, 32'hCAFE_7788});
        load(32'h14, SZ_W, 1'b0, 5'd8, 32'hCAFE_7788);
        wait_ready();

        rd0 = rd_cnt;
        store(32'h20, SZ_W, 32'hDEAD_BEEF, {32'h20, 32'hDEAD_BEEF});
        @(negedge clk);
        chk("sw_strobes", {62'h0, mem_read, mem_write}, 64'h1);
        chk("sw_wdata", {32'h0, mem_wdata}, {32'h0, 32'hDEAD_BEEF});
        wait_ready();
        chk("sw_no_read", 64'(rd_cnt), 64'(rd0));

`ifdef LSU_MISALIGN_TRAP_EN
        issue(32'h22, 1'b0, SZ_W, 1'b0, 32'h0, 5'd9);
        @(negedge clk);
        chk("misalign_pulse", {61'h0, misalign, mem_read, mem_write}, 64'h4);
        @(negedge clk);
        chk("misalign_clear", {63'h0, misalign}, 64'h0);
`else
        load(32'h22, SZ_W, 1'b0, 5'd9, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("trunc_addr", {misalign, mem_read, mem_addr}, {2'b01, 32'h20});
`endif
        wait_ready();

        // reset during RD of a sub-word store must never write
        wr0 = wr_cnt;
        wait_cyc = 5;
        issue(32'h31, 1'b1, SZ_B, 1'b0, 32'h77, 5'h0);
        @(negedge clk);
        chk("rd_before_reset", {63'h0, mem_read}, 64'h1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_outputs", {req_ready, mem_read, mem_write, wb_valid, misalign, mem_addr, mem_wdata[26:0]},
            64'h0);
        rst_n = 1'b1;
        wait_cyc = 0;
        @(negedge clk);
        chk("ready_after_abort", {63'h0, req_ready}, 64'h1);
        repeat (10) @(negedge clk);
        chk("no_write_after_abort", 64'(wr_cnt), 64'(wr0));
        chk("wb_queue_empty", 64'(wb_q.size()), 64'h0);
        chk("wr_queue_empty", 64'(wr_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter: ADDR_W, 32, byte-address width of requests and of mem_addr.
REQ-002 Parameter: TAG_W, 5, width of the destination-register tag carried from request to write-back.
REQ-003 Port: clk  in  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst_n  in  1  reset; synchronous, active-low.
REQ-005 Port: req_valid/req_ready  in/out  1/1  request handshake; transfer occurs when both are high on a rising edge.
REQ-006 Port: req_addr  in  ADDR_W  byte address.
REQ-007 Port: req_write  in  1  request type; 1 = store, 0 = load.
REQ-008 Port: req_size  in  2  access size; 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-009 Port: req_unsigned  in  1  load extension; 1 = zero-extend, 0 = sign-extend.
REQ-010 Port: req_wdata  in  32  store data, right-aligned.
REQ-011 Port: req_tag  in  TAG_W  destination-register tag.
REQ-012 Port: mem_addr  out  ADDR_W  word-aligned byte address (low 2 bits 0).
REQ-013 Port: mem_read / mem_write  out  1/1  word-memory strobes; never high together.
REQ-014 Port: mem_wdata  out  32  full word to the memory.
REQ-015 Port: mem_rdata  in  32  read word.
REQ-016 Port: mem_ack  in  1  memory completion; marks rdata valid or write done.
REQ-017 Port: wb_valid / wb_data / wb_tag  out  1/32/TAG_W  one-cycle load result.
REQ-018 Port: misalign  out  1  one-cycle misaligned-access flag; always 0 without LSU_MISALIGN_TRAP_EN.

Function
REQ-019 FSM states SHALL be IDLE, RD, MERGE, WR, RESP; req_ready=1 only in IDLE.
REQ-020 On acceptance, addr/size/unsigned/wdata/tag SHALL be latched; later req_* changes have no effect.
REQ-021 IDLE->RD on load or sub-word store; IDLE->WR on word store.
REQ-022 RD SHALL hold mem_read=1 until mem_ack; on ack the latched word is captured, then load->RESP, sub-word store->MERGE.
REQ-023 MERGE (one cycle) SHALL replace the addressed byte (addr[1:0]) or half (addr[1]) of the captured word with low bits of wdata; other bytes unchanged; ->WR.
REQ-024 WR SHALL hold mem_write=1 with mem_wdata until mem_ack, then ->IDLE.
REQ-025 RESP (one cycle) SHALL drive wb_valid=1, wb_tag, wb_data = selected byte/half/word shifted to bit 0 and sign- or zero-extended to 32; ->IDLE.
REQ-026 Load latency: accept edge N, mem_read from N+1, ack at edge M, wb_valid during the cycle after M; zero-wait-state load = 3 cycles from accept to wb_valid.
REQ-027 Stores SHALL never assert wb_valid.
REQ-028 Byte order is little-endian: byte k at bits [8k+7:8k].
REQ-029 mem_ack outside RD/WR SHALL be ignored.

Reset
REQ-030 rst_n low at an edge SHALL force IDLE, abort any in-flight access, and drop all outputs to 0 next cycle (req_ready=1 after release).
REQ-031 An aborted store SHALL never produce a partial mem_write after reset.

Configuration
REQ-032 Macro LSU_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL pulse misalign for one cycle after acceptance, issue no memory access, produce no wb_valid, return to IDLE.
REQ-033 Macro undefined: misaligned low bits SHALL be truncated (half uses addr[1], word uses whole word); misalign tied 0.

Structure
REQ-034 Shared package lsu_pkg SHALL hold size encodings (SZ_B, SZ_H, SZ_W) and the FSM state enum.
REQ-035 One sub-module lsu_align (combinational: byte-lane merge for stores, extract/extend for loads) SHALL be used.

Verification
REQ-036 Mem word 0x8081_7F01 at 0x10; LB 0x13 -> wb_data 0xFFFF_FF80; LBU 0x13 -> 0x0000_0080.
REQ-037 Same word; LH 0x12 -> 0xFFFF_8081; LW 0x10 with ack after 3 wait cycles -> wb_data 0x8081_7F01 on the cycle after ack.
REQ-038 SB 0xAB to 0x11 over 0x1122_3344 -> single mem_write of 0x1122_AB44 to 0x10, no wb_valid.
REQ-039 SW 0xDEAD_BEEF to 0x20 -> no mem_read; mem_write 0xDEAD_BEEF one cycle after accept.
REQ-040 rst_n low during RD of a sub-word store -> no mem_write ever; req_ready=1 after release.
REQ-041 LW 0x22 -> with macro: misalign=1, no strobes; without: reads word at 0x20.
